// File: rtl/mu_fetch_unit.sv
// Instruction fetch stage: PC register, ROM address, IR capture, valid/ready hand-off; range check under MU_FETCH_RANGE_CHECK_EN.
// Latency: ir_valid rises ROM_LAT cycles after entering FETCH; one instruction per ROM_LAT+1 cycles with ir_ready high.
// Backpressure: with ir_ready low, ir/pc/rom_addr hold; a redirect always wins and drops the held or in-flight word.
module mu_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
    parameter int                    ROM_DEPTH  = 64,
    parameter int                    ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] ir_pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic                  fetch_err
);

    localparam logic [1:0]            CNT_LAST = 2'(ROM_LAT - 1);
    localparam logic [DATA_WIDTH-1:0] FOUR     = DATA_WIDTH'(4);

`ifdef MU_FETCH_RANGE_CHECK_EN
    typedef enum logic [1:0] {S_FETCH, S_VALID, S_ERR} state_t;
`else
    typedef enum logic {S_FETCH, S_VALID} state_t;
`endif

    state_t                state;
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] pc;

    assign rom_addr = pc;
    assign ir_pc    = pc;
    assign pc_plus4 = pc + FOUR;

`ifdef MU_FETCH_RANGE_CHECK_EN
    // Upper bound kept one bit wider so a ROM ending at 2^32 cannot wrap.
    localparam logic [DATA_WIDTH:0] PC_LIMIT = {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * ROM_DEPTH);
    logic bad_pc;
    assign bad_pc = (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || ({1'b0, pc} >= PC_LIMIT);
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= TEXT_BASE;
            ir       <= '0;
            ir_valid <= 1'b0;
            cnt      <= 2'd0;
            state    <= S_FETCH;
`ifdef MU_FETCH_RANGE_CHECK_EN
            fetch_err <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // A coinciding handshake is consumed here: the held word is dropped, not re-presented.
            pc       <= redirect_pc;
            cnt      <= 2'd0;
            ir_valid <= 1'b0;
            state    <= S_FETCH;
`ifdef MU_FETCH_RANGE_CHECK_EN
            fetch_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
`ifdef MU_FETCH_RANGE_CHECK_EN
                    if (bad_pc) begin
                        state     <= S_ERR;
                        fetch_err <= 1'b1;
                        cnt       <= 2'd0;
                    end else
`endif
                    if (cnt == CNT_LAST) begin
                        ir       <= rom_q;
                        cnt      <= 2'd0;
                        ir_valid <= 1'b1;
                        state    <= S_VALID;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_VALID: begin
                    if (ir_ready) begin
                        pc       <= pc_plus4;
                        ir_valid <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
